// File: rtl/rv32_mem.sv
// rv32_mem: RV32 memory stage.
//   Takes EX results (pc/iw/alu/writeback target plus a load/store request),
//   drives a simple req/ready data-memory bus and forwards results to WB.
//   Ports:
//     clk, reset            - clock and synchronous active-high reset
//     pc_in, iw_in, alu_in  - EX results (alu_in is the effective address)
//     wb_reg_in/enable_in   - EX writeback target and enable
//     mem_io_oper_re/we_in  - load / store request; mem_io_wr_data_in = rs2
//     dmem_*                - data memory bus (req registered, word aligned)
//     pc/iw/wb_*_out        - registered outputs to WB
//     mem_stall             - combinational stall of upstream stages
//     mem_err               - one-cycle pulse on illegal or timed-out access
//     df_mem_*              - combinational bypass to ID
module rv32_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  input  logic        mem_io_oper_re_in,
  input  logic        mem_io_oper_we_in,
  input  logic [31:0] mem_io_wr_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        wb_from_mem_out,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   pcl_q, pcl_d, iwl_q, iwl_d;
  logic [4:0]    regl_q, regl_d;
  logic          enl_q, enl_d;
  logic [31:0]   pc_q, pc_d, iw_q, iw_d, data_q, data_d;
  logic [4:0]    reg_q, reg_d;
  logic          en_q, en_d, frm_q, frm_d, err_q, err_d;

  logic [2:0]  f3;
  logic [1:0]  a_lo;
  logic        is_mem, f3_ok, align_ok, legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, lane, ld_data;

  // Decode of the request presented by EX
  always_comb begin
    f3     = iw_in[14:12];
    a_lo   = alu_in[1:0];
    is_mem = mem_io_oper_re_in | mem_io_oper_we_in;
    f3_ok  = 1'b0;
    if (mem_io_oper_re_in && !mem_io_oper_we_in)
      f3_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (mem_io_oper_we_in && !mem_io_oper_re_in)
      f3_ok = f3 inside {3'b000, 3'b001, 3'b010};
    case (f3[1:0])
      2'b01:   align_ok = ~a_lo[0];
      2'b10:   align_ok = (a_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = f3_ok & align_ok;
    case (f3[1:0])
      2'b00:   be_new = 4'b0001 << a_lo;
      2'b01:   be_new = a_lo[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
    wdata_new = '0;
    if (mem_io_oper_we_in) begin
      case (f3[1:0])
        2'b00:   wdata_new = {4{mem_io_wr_data_in[7:0]}};
        2'b01:   wdata_new = {2{mem_io_wr_data_in[15:0]}};
        default: wdata_new = mem_io_wr_data_in;
      endcase
    end
  end

  // Load lane extraction from the latched access
  always_comb begin
    lane = dmem_rdata >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_data = {24'h0, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    pcl_d   = pcl_q;
    iwl_d   = iwl_q;
    regl_d  = regl_q;
    enl_d   = enl_q;
    // WB outputs default to a bubble
    pc_d    = '0;
    iw_d    = '0;
    data_d  = '0;
    reg_d   = '0;
    en_d    = 1'b0;
    frm_d   = 1'b0;
    err_d   = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && legal) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = mem_io_oper_we_in;
          addr_d    = {alu_in[31:2], 2'b00};
          wdata_d   = wdata_new;
          be_d      = be_new;
          f3_d      = f3;
          lo_d      = a_lo;
          pcl_d     = pc_in;
          iwl_d     = iw_in;
          regl_d    = wb_reg_in;
          enl_d     = wb_enable_in;
        end else begin
          // Non-memory ops pass through; illegal memory ops retire without writeback
          pc_d   = pc_in;
          iw_d   = iw_in;
          data_d = alu_in;
          reg_d  = wb_reg_in;
          en_d   = wb_enable_in & ~is_mem;
          err_d  = is_mem;
        end
      end
      BUSY: begin
        if (dmem_ready || cnt_q == TO_LAST) begin
          // The last waiting cycle already releases the stall so the
          // aborted instruction retires on the same edge as a completion.
          state_d = IDLE;
          req_d   = 1'b0;
          pc_d    = pcl_q;
          iw_d    = iwl_q;
          reg_d   = regl_q;
          if (dmem_ready) begin
            data_d = we_q ? '0 : ld_data;
            en_d   = enl_q & ~we_q;
            frm_d  = ~we_q;
          end else begin
            err_d  = 1'b1;
          end
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) mem_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      lo_q    <= '0;
      pcl_q   <= '0;
      iwl_q   <= '0;
      regl_q  <= '0;
      enl_q   <= 1'b0;
      pc_q    <= '0;
      iw_q    <= '0;
      data_q  <= '0;
      reg_q   <= '0;
      en_q    <= 1'b0;
      frm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      pcl_q   <= pcl_d;
      iwl_q   <= iwl_d;
      regl_q  <= regl_d;
      enl_q   <= enl_d;
      pc_q    <= pc_d;
      iw_q    <= iw_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
      en_q    <= en_d;
      frm_q   <= frm_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_be         = be_q;
  assign dmem_wdata      = wdata_q;
  assign pc_out          = pc_q;
  assign iw_out          = iw_q;
  assign wb_data_out     = data_q;
  assign wb_reg_out      = reg_q;
  assign wb_enable_out   = en_q;
  assign wb_from_mem_out = frm_q;
  assign mem_err         = err_q;
  assign df_mem_enable   = wb_enable_in & ~mem_io_oper_re_in;
  assign df_mem_reg      = wb_reg_in;
  assign df_mem_data     = alu_in;

endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: table-driven check of rv32_mem plus hand sequences for
// ready-in-IDLE and reset during BUSY.
module tb_rv32_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, iw_in, alu_in, mem_io_wr_data_in, dmem_rdata;
  logic [4:0]  wb_reg_in;
  logic        wb_enable_in, mem_io_oper_re_in, mem_io_oper_we_in, dmem_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] pc_out, iw_out, wb_data_out, df_mem_data;
  logic [4:0]  wb_reg_out, df_mem_reg;
  logic        wb_enable_out, wb_from_mem_out, mem_stall, mem_err, df_mem_enable;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_mem #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
    .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in),
    .mem_io_oper_re_in(mem_io_oper_re_in), .mem_io_oper_we_in(mem_io_oper_we_in),
    .mem_io_wr_data_in(mem_io_wr_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
    .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out),
    .wb_from_mem_out(wb_from_mem_out),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        re, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          ready_after;   // BUSY cycles before ready; -1 = never
    logic [4:0]  reg_in;
    logic        en_in;
    int          exp_stall, exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_daddr, exp_dwdata;
    logic        exp_we, exp_en, exp_mem, exp_err, chk_data;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic re, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ready_after,
                              input logic [4:0] reg_in, input logic en_in,
                              input int exp_stall, input int exp_req,
                              input logic [3:0] exp_be, input logic [31:0] exp_daddr,
                              input logic [31:0] exp_dwdata, input logic exp_we,
                              input logic exp_en, input logic exp_mem,
                              input logic exp_err, input logic chk_data,
                              input logic [31:0] exp_data);
    vec_t v;
    v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ready_after = ready_after; v.reg_in = reg_in; v.en_in = en_in;
    v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_be = exp_be;
    v.exp_daddr = exp_daddr; v.exp_dwdata = exp_dwdata; v.exp_we = exp_we;
    v.exp_en = exp_en; v.exp_mem = exp_mem; v.exp_err = exp_err;
    v.chk_data = chk_data; v.exp_data = exp_data;
    return v;
  endfunction

  vec_t vecs[$];

  task automatic drive_nop();
    mem_io_oper_re_in = 1'b0;
    mem_io_oper_we_in = 1'b0;
    wb_enable_in      = 1'b0;
    dmem_ready        = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   stall_n, req_n, busy;
    bit   done;
    logic [31:0] exp_pc;

    //        re we f3     addr          wdata         rdata       rdy reg en  st rq be       daddr         dwdata        we en mem err cd data
    vecs.push_back(mk(0, 0, 3'd0, 32'h0000_1234, 32'h0,        32'h0,        0, 5, 1,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 1, 0, 0, 1, 32'h0000_1234));
    vecs.push_back(mk(0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0,        32'h0,        0, 3, 0,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(1, 0, 3'd0, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 7, 1, 1, 1, 4'b1000, 32'h100,     32'h0,        0, 1, 1, 0, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, 3'd4, 32'h0000_0101, 32'h0,        32'h0000_AB00, 0, 8, 1, 1, 1, 4'b0010, 32'h100,     32'h0,        0, 1, 1, 0, 1, 32'h0000_00AB));
    vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0202, 32'h0,        32'h8001_0000, 1, 9, 1, 2, 2, 4'b1100, 32'h200,     32'h0,        0, 1, 1, 0, 1, 32'hFFFF_8001));
    vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0200, 32'h0,        32'h1234_F00F, 0, 10, 1, 1, 1, 4'b0011, 32'h200,    32'h0,        0, 1, 1, 0, 1, 32'h0000_F00F));
    vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0300, 32'h0,        32'hCAFE_BABE, 2, 11, 1, 3, 3, 4'b1111, 32'h300,    32'h0,        0, 1, 1, 0, 1, 32'hCAFE_BABE));
    vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0,      3, 0, 0,  4, 4, 4'b1100, 32'h200,     32'hABCD_ABCD, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd0, 32'h0000_0005, 32'h1234_56EF, 32'h0,      0, 0, 0,  1, 1, 4'b0010, 32'h4,       32'hEFEF_EFEF, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd2, 32'h0000_0008, 32'h89AB_CDEF, 32'h0,      0, 0, 0,  1, 1, 4'b1111, 32'h8,       32'h89AB_CDEF, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        0, 4, 1,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h0000_0103, 32'h0,        32'h0,        0, 4, 1,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        0, 4, 1,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd4, 32'h0000_0100, 32'h1,        32'h0,        0, 0, 0,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 3'd2, 32'h0000_0100, 32'h1,        32'h0,        0, 4, 1,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd1, 32'h0000_0201, 32'h1,        32'h0,        0, 0, 0,  0, 0, 4'b0000, 32'h0,       32'h0,        0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd5, 32'h0000_0010, 32'h0,        32'h0,       -1, 6, 1, 16, 16, 4'b0011, 32'h10,     32'h0,        0, 0, 0, 1, 0, 32'h0));

    reset = 1'b1;
    pc_in = '0; iw_in = '0; alu_in = '0; mem_io_wr_data_in = '0; dmem_rdata = '0;
    wb_reg_in = '0;
    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'b0, mem_stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_req", {31'b0, dmem_req}, 32'd0);
    chk("reset_wb_en", {31'b0, wb_enable_out}, 32'd0);
    chk("reset_err", {31'b0, mem_err}, 32'd0);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      exp_pc = 32'h1000 + 32'(i * 4);
      @(posedge clk); #1;
      pc_in             = exp_pc;
      iw_in             = {17'b0, v.f3, 12'h003};
      alu_in            = v.addr;
      mem_io_wr_data_in = v.wdata;
      dmem_rdata        = v.rdata;
      wb_reg_in         = v.reg_in;
      wb_enable_in      = v.en_in;
      mem_io_oper_re_in = v.re;
      mem_io_oper_we_in = v.we;
      dmem_ready        = 1'b0;
      stall_n = 0; req_n = 0; busy = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        dmem_ready = dmem_req && (busy == v.ready_after);
        #1;
        if (c == 0) begin
          chk($sformatf("v%0d_df_en", i), {31'b0, df_mem_enable}, {31'b0, v.en_in & ~v.re});
          chk($sformatf("v%0d_df_reg", i), {27'b0, df_mem_reg}, {27'b0, v.reg_in});
          chk($sformatf("v%0d_df_data", i), df_mem_data, v.addr);
        end
        if (dmem_req) begin
          if (req_n == 0) begin
            chk($sformatf("v%0d_daddr", i), dmem_addr, v.exp_daddr);
            chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, v.exp_be});
            chk($sformatf("v%0d_dwdata", i), dmem_wdata, v.exp_dwdata);
            chk($sformatf("v%0d_dwe", i), {31'b0, dmem_we}, {31'b0, v.exp_we});
          end
          chk($sformatf("v%0d_bubble", i), {30'b0, wb_enable_out, wb_from_mem_out}, 32'd0);
          req_n++;
          busy++;
        end
        if (mem_stall) stall_n++;
        else done = 1;
        @(posedge clk); #1;
      end
      if (!done) begin
        n_chk++; n_fail++;
        $display("FAIL v%0d_timeout: stall never released within 40 cycles", i);
      end
      dmem_ready = 1'b0;
      chk($sformatf("v%0d_stall_cycles", i), stall_n, v.exp_stall);
      chk($sformatf("v%0d_req_cycles", i), req_n, v.exp_req);
      chk($sformatf("v%0d_req_drop", i), {31'b0, dmem_req}, 32'd0);
      chk($sformatf("v%0d_wb_en", i), {31'b0, wb_enable_out}, {31'b0, v.exp_en});
      chk($sformatf("v%0d_from_mem", i), {31'b0, wb_from_mem_out}, {31'b0, v.exp_mem});
      chk($sformatf("v%0d_err", i), {31'b0, mem_err}, {31'b0, v.exp_err});
      chk($sformatf("v%0d_wb_reg", i), {27'b0, wb_reg_out}, {27'b0, v.reg_in});
      chk($sformatf("v%0d_pc", i), pc_out, exp_pc);
      if (v.chk_data) chk($sformatf("v%0d_wb_data", i), wb_data_out, v.exp_data);
      drive_nop();
      @(posedge clk); #1;
      chk($sformatf("v%0d_err_pulse", i), {31'b0, mem_err}, 32'd0);
    end

    // dmem_ready asserted while IDLE must not complete the capture cycle
    @(posedge clk); #1;
    pc_in = 32'h2000; iw_in = {17'b0, 3'd2, 12'h003}; alu_in = 32'h20;
    wb_reg_in = 5'd12; wb_enable_in = 1'b1;
    mem_io_oper_re_in = 1'b1; dmem_rdata = 32'h0BAD_F00D; dmem_ready = 1'b1;
    #1;
    chk("idle_ready_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    chk("idle_ready_req", {31'b0, dmem_req}, 32'd1);
    chk("idle_ready_busy_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("idle_ready_data", wb_data_out, 32'h0BAD_F00D);
    chk("idle_ready_wb_en", {31'b0, wb_enable_out}, 32'd1);
    drive_nop();

    // Reset during the second BUSY cycle of a store aborts it cleanly
    @(posedge clk); #1;
    pc_in = 32'h3000; iw_in = {17'b0, 3'd2, 12'h023}; alu_in = 32'h40;
    mem_io_wr_data_in = 32'h55; wb_reg_in = 5'd0; wb_enable_in = 1'b0;
    mem_io_oper_we_in = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy1_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_stall_low", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    chk("rst_wb_en", {31'b0, wb_enable_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    reset = 1'b0;
    drive_nop();
    @(posedge clk); #1;
    chk("rst_after_err", {31'b0, mem_err}, 32'd0);
    chk("rst_after_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_after_stall", {31'b0, mem_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
